uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter that answers data-bus accesses from the pipelined core. It sits on the data bus beside dmem and uses the same request signals: we, address, write data, funct3 Control and read data. Stores to its window queue bytes in a small FIFO, which an FSM serialises 8N1 on tx. Loads return status and the baud divisor, and its rd can be OR-merged with dmem's rd.

Parameters:
BASE_ADDR, 32'hFFFF_0000, window base; 16-byte aligned; decode uses a[31:4].
DEPTH, 4, FIFO entries; range 2..7.
DIV_RESET, 16'd868, reset value of the baud divisor in clocks per bit.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
we  input  1  store strobe (MemWriteM).
a  input  32  byte address (DataAdrM).
wd  input  32  store data (WriteDataM), unshifted register value.
Control  input  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
rd  output  32  combinational load data; 0 when the window is not selected.
tx  output  1  serial line, registered, idle high.

Behaviour:
- sel = (a[31:4] == BASE_ADDR[31:4]). Register offsets are a[3:2]:
  - 0 TXDATA: write-only, reads 0.
  - 1 STATUS.
  - 2 DIV.
  - 3 reserved: reads 0, writes ignored.
- STATUS fields:
  - bit0 busy (FSM not IDLE).
  - bit1 full.
  - bit2 empty.
  - bit3 overflow (sticky, write-1-to-clear).
  - bits[6:4] FIFO count.
  - all other bits 0.
- Writes take effect only when we && sel && a[1:0]==0; any other byte offset is ignored.
  - TXDATA: push wd[7:0] for any store width.
  - STATUS: overflow cleared when wd[3]=1; all other bits read-only.
  - DIV: sb writes DIV[7:0] only; sh/sw write DIV[15:0]. A written value of 0 is stored as 1.
- Full check uses the count from before the edge. A push while full is dropped even if the FSM pops that same cycle, and sets overflow.
- Reads have no side effects. The word is selected by a[3:2]; the byte or half lane by a[1:0]. Extension follows Control: b/h sign-extend, bu/hu zero-extend, w returns the word (a[1:0] ignored).
- FSM states: IDLE, START, DATA, STOP. Registers: bit counter 0..7, divisor counter, shift register, latched divisor.
  - IDLE: tx=1. If the FIFO is not empty, pop into the shift register, latch DIV, and go to START.
  - START: tx=0 for DIV cycles, then go to DATA.
  - DATA: tx = shift[0], LSB first, DIV cycles per bit, 8 bits, then go to STOP.
  - STOP: tx=1 for DIV cycles. On the last cycle, if the FIFO is not empty, pop, latch DIV and go to START directly with no idle gap; otherwise go to IDLE.
- tx is registered from the next state. For a store sampled at edge E with FSM idle, tx goes low at E+1. One frame lasts exactly 10*DIV cycles.
- A DIV write during a frame does not affect that frame; the divisor is latched at frame start.
- Reset values: tx=1, state IDLE, FIFO empty (count 0), overflow 0, DIV=DIV_RESET, all counters 0. rd is combinational and carries no reset value.
- Reset mid-frame aborts the frame and discards FIFO contents; tx is high from the reset edge.

Decomposition:
- Package uart_pkg:
  - state enum.
  - register offset constants (TXDATA=0, STATUS=1, DIV=2).
  - funct3 load/store constants.
  - STATUS bit positions.
- Sub-module uart_tx_fifo: synchronous FIFO with push, pop, full, empty and count, sized by DEPTH, same clk/reset. The top level holds decode, read mux, extension logic and the FSM.

Test Plan:
1. Reset, then lw at BASE+4 -> rd=32'h0000_0004; tx=1. lw at BASE+8 -> rd=868.
2. sw 4 to BASE+8, then sw 32'h55 to BASE+0 at edge E -> tx low over E+1..E+4, then 1,0,1,0,1,0,1,0 for 4 cycles each, stop high. busy=1 for 40 cycles, then STATUS reads 32'h04.
3. DIV=4; six back-to-back sw to TXDATA with bytes 01..06 -> bytes 01..05 sent on tx in order, back-to-back, 200 cycles with no gap. 06 is dropped and STATUS bit3=1. sw 32'h8 to STATUS clears bit3.
4. sb 0 to DIV -> lw DIV=1. sh 32'hFFFF_8003 -> DIV=32'h8003. lh at BASE+8 -> 32'hFFFF_8003; lhu -> 32'h0000_8003. lb at BASE+9 -> 32'hFFFF_FF80.
5. Assert reset for 1 cycle mid-DATA with 2 bytes queued -> tx=1 from the reset edge, STATUS=32'h04, nothing further transmitted.
6. sw 32'hAA to BASE+16 and to BASE+1 -> no push, tx stays 1. lw at BASE+16 -> rd=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter:
// FSM states, register offsets, funct3 codes, STATUS layout and the load-lane extender.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV    = 2'd2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int ST_BUSY_BIT  = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_EMPTY_BIT = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_CNT_LSB   = 4;

    // Lane select by byte offset, then sign/zero extension chosen by funct3.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_BU:   r = {24'h0, b};
            F3_HU:   r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the serialiser; push/pop take effect on the clock edge, data out is
// the head entry combinationally. Push while full and pop while empty are ignored.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [2:0] count_o
);

    localparam logic [2:0] CAP  = 3'(DEPTH);
    localparam logic [2:0] LAST = 3'(DEPTH - 1);

    logic [7:0] mem_q [8];
    logic [2:0] wr_ptr_q, rd_ptr_q, count_q;
    logic       do_push, do_pop;

    assign full_o  = (count_q == CAP);
    assign empty_o = (count_q == 3'd0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dat_o   = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 3'd0;
            rd_ptr_q <= 3'd0;
            count_q  <= 3'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == LAST) ? 3'd0 : wr_ptr_q + 3'd1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST) ? 3'd0 : rd_ptr_q + 3'd1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: combinational load data, tx low one edge after a
// store to an idle unit; stores to a full FIFO are dropped and flagged in STATUS.overflow.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          DEPTH     = 4,
    parameter logic [15:0] DIV_RESET = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [2:0]  Control,
    output logic [31:0] rd,
    output logic        tx
);

    logic        sel, wr_en, push, pop, last_tick;
    logic        fifo_full, fifo_empty;
    logic [2:0]  fifo_count;
    logic [7:0]  fifo_dat;
    logic        ovf_q;
    logic [15:0] div_q, div_d;
    tx_state_e   state_q;
    logic [2:0]  bit_cnt_q;
    logic [15:0] div_cnt_q, div_lat_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic [31:0] status_word, reg_word;
    logic        unused_wd;

    assign sel       = (a[31:4] == BASE_ADDR[31:4]);
    assign wr_en     = we && sel && (a[1:0] == 2'b00);
    assign push      = wr_en && (a[3:2] == OFF_TXDATA);
    assign last_tick = (div_cnt_q == div_lat_q - 16'd1);
    assign pop       = !fifo_empty && ((state_q == ST_IDLE) ||
                                       ((state_q == ST_STOP) && last_tick));
    assign unused_wd = ^wd[31:16];

    uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .dat_i   (wd[7:0]),
        .dat_o   (fifo_dat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A byte store only replaces the low byte; a zero divisor would never end a bit.
    always_comb begin
        div_d = div_q;
        if (Control[1:0] == 2'b00) begin
            div_d[7:0] = wd[7:0];
        end else begin
            div_d = wd[15:0];
        end
        if (div_d == 16'd0) begin
            div_d = 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= DIV_RESET;
            ovf_q <= 1'b0;
        end else begin
            if (wr_en && (a[3:2] == OFF_DIV)) begin
                div_q <= div_d;
            end
            if (push && fifo_full) begin
                ovf_q <= 1'b1;
            end else if (wr_en && (a[3:2] == OFF_STATUS) && wd[ST_OVF_BIT]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_comb begin
        status_word                   = 32'h0;
        status_word[ST_BUSY_BIT]      = (state_q != ST_IDLE);
        status_word[ST_FULL_BIT]      = fifo_full;
        status_word[ST_EMPTY_BIT]     = fifo_empty;
        status_word[ST_OVF_BIT]       = ovf_q;
        status_word[ST_CNT_LSB +: 3]  = fifo_count;
    end

    always_comb begin
        case (a[3:2])
            OFF_STATUS: reg_word = status_word;
            OFF_DIV:    reg_word = {16'h0, div_q};
            default:    reg_word = 32'h0;
        endcase
    end

    assign rd = sel ? load_extend(reg_word, a[1:0], Control) : 32'h0;

    // tx_q is loaded from the state being entered, so the line changes on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tx_q      <= 1'b1;
            bit_cnt_q <= 3'd0;
            div_cnt_q <= 16'd0;
            div_lat_q <= 16'd0;
            shift_q   <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q   <= fifo_dat;
                        div_lat_q <= div_q;
                        div_cnt_q <= 16'd0;
                        bit_cnt_q <= 3'd0;
                        state_q   <= ST_START;
                        tx_q      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (last_tick) begin
                        div_cnt_q <= 16'd0;
                        state_q   <= ST_DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        div_cnt_q <= div_cnt_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (last_tick) begin
                        div_cnt_q <= 16'd0;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_q <= 3'd0;
                            state_q   <= ST_STOP;
                            tx_q      <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (last_tick) begin
                        div_cnt_q <= 16'd0;
                        if (pop) begin
                            shift_q   <= fifo_dat;
                            div_lat_q <= div_q;
                            bit_cnt_q <= 3'd0;
                            state_q   <= ST_START;
                            tx_q      <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register/load table plus frame, back-to-back,
// overflow and mid-frame reset sequences.
module tb_uart_tx_mmio;
    import uart_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int          NV   = 28;

    logic        clk, reset, we, tx;
    logic [31:0] a, wd, rd;
    logic [2:0]  Control;

    int passed = 0;
    int total  = 0;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        tbl [NV];
    logic [31:0] val;
    logic [40:0] txc, bc;
    logic [39:0] cap [5];
    int          zeros;

    uart_tx_mmio #(
        .BASE_ADDR (BASE),
        .DEPTH     (4),
        .DIV_RESET (16'd868)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .a       (a),
        .wd      (wd),
        .Control (Control),
        .rd      (rd),
        .tx      (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
        we = 1'b1; a = addr; wd = data; Control = f3;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic rdw(input logic [31:0] addr, input logic [2:0] f3, output logic [31:0] v);
        @(negedge clk);
        we = 1'b0; a = addr; Control = f3;
        #1 v = rd;
    endtask

    // Expected line level for each of the 40 cycles of one frame at 4 clocks per bit.
    function automatic logic [39:0] frame_exp(input logic [7:0] b);
        logic [39:0] f;
        for (int p = 0; p < 40; p++) begin
            int s;
            s = p / 4;
            if (s == 0)      f[p] = 1'b0;
            else if (s == 9) f[p] = 1'b1;
            else             f[p] = b[s-1];
        end
        return f;
    endfunction

    initial begin
        tbl[0]  = '{1'b0, BASE + 32'd4,  32'h0,         F3_W,  32'h0000_0004, "rst_status"};
        tbl[1]  = '{1'b0, BASE + 32'd8,  32'h0,         F3_W,  32'd868,       "rst_div"};
        tbl[2]  = '{1'b0, BASE,          32'h0,         F3_W,  32'h0,         "txdata_rd0"};
        tbl[3]  = '{1'b1, BASE + 32'd12, 32'h3,         F3_W,  32'h0,         "wr_reserved"};
        tbl[4]  = '{1'b0, BASE + 32'd12, 32'h0,         F3_W,  32'h0,         "reserved_rd0"};
        tbl[5]  = '{1'b1, BASE + 32'd8,  32'h4,         F3_W,  32'h0,         "wr_div4"};
        tbl[6]  = '{1'b0, BASE + 32'd8,  32'h0,         F3_W,  32'h4,         "div_sw4"};
        tbl[7]  = '{1'b1, BASE + 32'd8,  32'h0,         F3_B,  32'h0,         "wr_div_sb0"};
        tbl[8]  = '{1'b0, BASE + 32'd8,  32'h0,         F3_W,  32'h1,         "div_sb0_is1"};
        tbl[9]  = '{1'b1, BASE + 32'd8,  32'hFFFF_8003, F3_H,  32'h0,         "wr_div_sh"};
        tbl[10] = '{1'b0, BASE + 32'd8,  32'h0,         F3_W,  32'h0000_8003, "div_sh"};
        tbl[11] = '{1'b0, BASE + 32'd8,  32'h0,         F3_H,  32'hFFFF_8003, "lh_div"};
        tbl[12] = '{1'b0, BASE + 32'd8,  32'h0,         F3_HU, 32'h0000_8003, "lhu_div"};
        tbl[13] = '{1'b0, BASE + 32'd9,  32'h0,         F3_B,  32'hFFFF_FF80, "lb_div_b1"};
        tbl[14] = '{1'b0, BASE + 32'd9,  32'h0,         F3_BU, 32'h0000_0080, "lbu_div_b1"};
        tbl[15] = '{1'b0, BASE + 32'd10, 32'h0,         F3_H,  32'h0,         "lh_div_hi"};
        tbl[16] = '{1'b1, BASE + 32'd10, 32'h55,        F3_B,  32'h0,         "wr_div_misal"};
        tbl[17] = '{1'b0, BASE + 32'd8,  32'h0,         F3_W,  32'h0000_8003, "div_misal_ign"};
        tbl[18] = '{1'b1, BASE + 32'd8,  32'h1234_00AB, F3_B,  32'h0,         "wr_div_sb"};
        tbl[19] = '{1'b0, BASE + 32'd8,  32'h0,         F3_HU, 32'h0000_80AB, "div_sb_low"};
        tbl[20] = '{1'b1, BASE + 32'd16, 32'hAA,        F3_W,  32'h0,         "wr_outside"};
        tbl[21] = '{1'b1, BASE + 32'd1,  32'hAA,        F3_W,  32'h0,         "wr_tx_misal"};
        tbl[22] = '{1'b0, BASE + 32'd16, 32'h0,         F3_W,  32'h0,         "outside_rd0"};
        tbl[23] = '{1'b0, BASE + 32'd4,  32'h0,         F3_W,  32'h0000_0004, "status_no_push"};
        tbl[24] = '{1'b0, BASE + 32'd4,  32'h0,         F3_B,  32'h0000_0004, "lb_status"};
        tbl[25] = '{1'b1, BASE + 32'd8,  32'h0,         F3_W,  32'h0,         "wr_div_sw0"};
        tbl[26] = '{1'b0, BASE + 32'd8,  32'h0,         F3_W,  32'h1,         "div_sw0_is1"};
        tbl[27] = '{1'b0, 32'h0000_1008, 32'h0,         F3_W,  32'h0,         "unsel_rd0"};

        reset = 1'b1; we = 1'b0; a = 32'h0; wd = 32'h0; Control = F3_W;
        repeat (2) @(posedge clk);
        #1 chk("rst_tx", 64'(tx), 64'h1);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].is_wr) begin
                wr(tbl[i].addr, tbl[i].data, tbl[i].f3);
            end else begin
                rdw(tbl[i].addr, tbl[i].f3, val);
                chk(tbl[i].name, 64'(val), 64'(tbl[i].exp));
            end
        end
        zeros = 0;
        repeat (4) begin
            @(negedge clk);
            if (tx !== 1'b1) zeros++;
        end
        chk("idle_tx_high", 64'(zeros), 64'h0);

        // Single frame of 0x55 at 4 clocks/bit; DIV rewritten to 8 one edge into the frame.
        wr(BASE + 32'd8, 32'h4, F3_W);
        @(negedge clk);
        we = 1'b1; a = BASE; wd = 32'h55; Control = F3_W;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 41; k++) begin
            if (k == 1) begin a = BASE + 32'd8; wd = 32'h8; end
            @(posedge clk);
            @(negedge clk);
            we = 1'b0; a = BASE + 32'd4; Control = F3_W;
            #1;
            txc[k-1] = tx;
            bc[k-1]  = rd[0];
        end
        chk("frame55_tx", 64'(txc), 64'({1'b1, frame_exp(8'h55)}));
        chk("frame55_busy", 64'(bc), 64'({1'b0, {40{1'b1}}}));
        rdw(BASE + 32'd4, F3_W, val);
        chk("status_after_frame", 64'(val), 64'h4);
        rdw(BASE + 32'd8, F3_W, val);
        chk("div_written_midframe", 64'(val), 64'h8);
        wr(BASE + 32'd8, 32'h4, F3_W);

        // Six back-to-back stores: five frames with no gap, sixth byte dropped.
        @(negedge clk);
        we = 1'b1; a = BASE; wd = 32'h1; Control = F3_W;
        @(posedge clk);
        #1;
        zeros = 0;
        for (int k = 1; k <= 205; k++) begin
            if (k <= 5) wd = 32'(k + 1);
            else        we = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (k <= 200) cap[(k-1)/40][(k-1)%40] = tx;
            else if (tx !== 1'b1) zeros++;
        end
        for (int f = 0; f < 5; f++) begin
            chk($sformatf("b2b_frame%0d", f + 1), 64'(cap[f]), 64'(frame_exp(8'(f + 1))));
        end
        chk("b2b_idle_after", 64'(zeros), 64'h0);
        rdw(BASE + 32'd4, F3_W, val);
        chk("status_overflow", 64'(val), 64'h0C);
        wr(BASE + 32'd4, 32'h8, F3_W);
        rdw(BASE + 32'd4, F3_W, val);
        chk("status_ovf_cleared", 64'(val), 64'h04);

        // Reset mid-DATA with two bytes queued.
        wr(BASE, 32'h0, F3_W);
        wr(BASE, 32'h0, F3_W);
        wr(BASE, 32'h0, F3_W);
        repeat (6) @(posedge clk);
        rdw(BASE + 32'd4, F3_W, val);
        chk("status_midframe", 64'(val), 64'h21);
        chk("tx_low_midframe", 64'(tx), 64'h0);
        reset = 1'b1;
        @(posedge clk);
        #1 chk("tx_at_reset_edge", 64'(tx), 64'h1);
        @(negedge clk) reset = 1'b0;
        rdw(BASE + 32'd4, F3_W, val);
        chk("status_after_reset", 64'(val), 64'h04);
        rdw(BASE + 32'd8, F3_W, val);
        chk("div_after_reset", 64'(val), 64'd868);
        zeros = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) zeros++;
        end
        chk("no_tx_after_reset", 64'(zeros), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
